// File: rtl/qsn_pkg.sv
// qsn_pkg
//   Shared constants, types and helpers for the 85-lane QSN return path.
//   - CHECK_PARALLELISM     : lane count P, also the rotation modulus
//   - QUAN_SIZE             : number of quantised bit-planes
//   - BITWIDTH_SHIFT_FACTOR : width of a shift factor
//   - inv_shift(s)          : inverse rotation amount (P-s)%P
//   - rotate_down(d, w)     : one barrel stage, result[i] = d[(i+w) mod P]
package qsn_pkg;

  localparam int CHECK_PARALLELISM     = 85;
  localparam int QUAN_SIZE             = 4;
  localparam int BITWIDTH_SHIFT_FACTOR = 7;

  typedef logic [BITWIDTH_SHIFT_FACTOR-1:0]            shift_t;
  typedef logic [CHECK_PARALLELISM-1:0]                lanes_t;
  typedef logic [QUAN_SIZE-1:0][CHECK_PARALLELISM-1:0] planes_t;

  // Only called with s < P, so the subtraction never goes negative.
  function automatic shift_t inv_shift(input shift_t s);
    return shift_t'((CHECK_PARALLELISM - int'(s)) % CHECK_PARALLELISM);
  endfunction

  // Applying these stages one after another adds their amounts mod P, so the
  // bits of r (64..1) together move lane (i+r) mod P onto lane i.
  function automatic lanes_t rotate_down(input lanes_t d, input int w);
    lanes_t res;
    for (int i = 0; i < CHECK_PARALLELISM; i++) begin
      res[i] = d[(i + w) % CHECK_PARALLELISM];
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_factor_fifo.sv
// shift_factor_fifo
//   Synchronous FIFO holding forward shift factors until their return data
//   arrives. Push is ignored while full and pop is ignored while empty.
//   Ports:
//     sys_clk, rstn  : clock, synchronous active-low clear
//     push, din      : write request and data
//     pop, dout      : read request and head-of-queue data (combinational)
//     full, empty    : status decoded from the registered level
//     level          : entries currently stored (0..DEPTH)
module shift_factor_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qsn_inverse_shifter_85b.sv
// qsn_inverse_shifter_85b
//   Return-path de-permutation for the 85-lane QSN. Forward shift factors are
//   queued as issued; each returning CNU word pops one and is rotated back by
//   r=(P-s)%P through a 7-stage log barrel shifter spread over
//   BS_PIPELINE_LEVEL register stages.
//   Ports:
//     sys_clk, rstn                      : clock, synchronous active-low reset
//     fwd_shift_valid/factor/ready       : forward shift factor push handshake
//     sw_in_valid, sw_in_bit0..3         : permuted return bit-planes
//     sw_out_valid, sw_out_bit0..3       : bit-planes back in VNU order
//     fifo_level                         : shift factors currently queued
//     err_range, err_underflow           : sticky error flags
module qsn_inverse_shifter_85b
  import qsn_pkg::*;
#(
  parameter int BS_PIPELINE_LEVEL = 2,
  parameter int SHIFT_FIFO_DEPTH  = 8
) (
  input  logic                                sys_clk,
  input  logic                                rstn,
  input  logic                                fwd_shift_valid,
  input  logic [BITWIDTH_SHIFT_FACTOR-1:0]    fwd_shift_factor,
  output logic                                fwd_shift_ready,
  input  logic                                sw_in_valid,
  input  logic [CHECK_PARALLELISM-1:0]        sw_in_bit0,
  input  logic [CHECK_PARALLELISM-1:0]        sw_in_bit1,
  input  logic [CHECK_PARALLELISM-1:0]        sw_in_bit2,
  input  logic [CHECK_PARALLELISM-1:0]        sw_in_bit3,
  output logic                                sw_out_valid,
  output logic [CHECK_PARALLELISM-1:0]        sw_out_bit0,
  output logic [CHECK_PARALLELISM-1:0]        sw_out_bit1,
  output logic [CHECK_PARALLELISM-1:0]        sw_out_bit2,
  output logic [CHECK_PARALLELISM-1:0]        sw_out_bit3,
  output logic [$clog2(SHIFT_FIFO_DEPTH):0]   fifo_level,
  output logic                                err_range,
  output logic                                err_underflow
);

  logic   fifo_full;
  logic   fifo_empty;
  logic   range_ok;
  shift_t head_s;
  shift_t r0;

  assign range_ok        = (fwd_shift_factor < shift_t'(CHECK_PARALLELISM));
  assign fwd_shift_ready = ~fifo_full;

  // The FIFO gates push with full and pop with empty itself, so a push and a
  // pop on an empty FIFO leave the pushed factor queued (no bypass).
  shift_factor_fifo #(
    .WIDTH (BITWIDTH_SHIFT_FACTOR),
    .DEPTH (SHIFT_FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .push    (fwd_shift_valid & range_ok),
    .din     (fwd_shift_factor),
    .pop     (sw_in_valid),
    .dout    (head_s),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Underflowing data passes straight through.
  assign r0 = (sw_in_valid && !fifo_empty) ? inv_shift(head_s) : '0;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      err_range     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (fwd_shift_valid && fwd_shift_ready && !range_ok) err_range <= 1'b1;
      if (sw_in_valid && fifo_empty)                       err_underflow <= 1'b1;
    end
  end

  planes_t pipe_d [BS_PIPELINE_LEVEL];
  shift_t  pipe_r [BS_PIPELINE_LEVEL];
  logic    pipe_v [BS_PIPELINE_LEVEL];

  // Barrel stage k (weight 2^(6-k)) sits in front of register level
  // floor(k*LEVELS/7), so stages are spread evenly and LEVELS=1 puts all
  // seven ahead of the single output register.
  for (genvar l = 0; l < BS_PIPELINE_LEVEL; l++) begin : g_lvl
    planes_t d_in;
    planes_t d_rot;
    shift_t  r_in;
    logic    v_in;

    if (l == 0) begin : g_first
      assign d_in = {sw_in_bit3, sw_in_bit2, sw_in_bit1, sw_in_bit0};
      assign r_in = r0;
      assign v_in = sw_in_valid;
    end else begin : g_next
      assign d_in = pipe_d[l-1];
      assign r_in = pipe_r[l-1];
      assign v_in = pipe_v[l-1];
    end

    always_comb begin
      d_rot = d_in;
      for (int k = 0; k < BITWIDTH_SHIFT_FACTOR; k++) begin
        if (((k * BS_PIPELINE_LEVEL) / BITWIDTH_SHIFT_FACTOR) == l &&
            r_in[BITWIDTH_SHIFT_FACTOR-1-k]) begin
          for (int q = 0; q < QUAN_SIZE; q++) begin
            d_rot[q] = rotate_down(d_rot[q], 1 << (BITWIDTH_SHIFT_FACTOR-1-k));
          end
        end
      end
    end

    // Data and residual only load on valid; bubbles move just the valid bit.
    always_ff @(posedge sys_clk) begin
      if (!rstn) begin
        pipe_v[l] <= 1'b0;
        pipe_d[l] <= '0;
        pipe_r[l] <= '0;
      end else begin
        pipe_v[l] <= v_in;
        if (v_in) begin
          pipe_d[l] <= d_rot;
          pipe_r[l] <= r_in;
        end
      end
    end
  end

  assign sw_out_valid = pipe_v[BS_PIPELINE_LEVEL-1];
  assign sw_out_bit0  = pipe_d[BS_PIPELINE_LEVEL-1][0];
  assign sw_out_bit1  = pipe_d[BS_PIPELINE_LEVEL-1][1];
  assign sw_out_bit2  = pipe_d[BS_PIPELINE_LEVEL-1][2];
  assign sw_out_bit3  = pipe_d[BS_PIPELINE_LEVEL-1][3];

endmodule
